// File: rtl/ps2_keycode_queue.sv
// PS/2 set-2 byte parser feeding a DEPTH-entry key event FIFO with valid/ack pop,
// optional typematic repeat suppression and a sticky overflow flag.
module ps2_keycode_queue #(
   parameter int DEPTH         = 8,
   parameter int FILTER_REPEAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ps2_key_en,
   input  logic [7:0]               ps2_key_data,
   input  logic                     event_ack,
   input  logic                     ovf_clr,
   output logic                     event_ready,
   output logic [7:0]               event_code,
   output logic                     event_ext,
   output logic                     event_make,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state_q, state_d;
   logic          held_vld_q, held_vld_d;
   logic          held_ext_q, held_ext_d;
   logic [7:0]    held_code_q, held_code_d;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [9:0]    mem_q [DEPTH];
   logic [9:0]    mem_d [DEPTH];

   logic          is_discard, evt_vld, evt_ext, evt_make, held_match;
   logic          push, pop, full, wr, ovf_set;
   logic [9:0]    head;

   // Parser: prefixes only steer state, discard bytes resync to IDLE.
   always_comb begin
      state_d  = state_q;
      evt_vld  = 1'b0;
      evt_ext  = (state_q == EXT) || (state_q == EXT_BRK);
      evt_make = (state_q == IDLE) || (state_q == EXT);
      case (ps2_key_data)
         8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
         8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
         default:                    is_discard = 1'b0;
      endcase
      if (ps2_key_en) begin
         if (ps2_key_data == 8'hE0) begin
            state_d = EXT;
         end else if (ps2_key_data == 8'hF0) begin
            case (state_q)
               IDLE:    state_d = BRK;
               EXT:     state_d = EXT_BRK;
               default: state_d = state_q;
            endcase
         end else if (is_discard) begin
            state_d = IDLE;
         end else begin
            evt_vld = 1'b1;
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      held_vld_d  = held_vld_q;
      held_ext_d  = held_ext_q;
      held_code_d = held_code_q;
      push        = evt_vld;
      held_match  = held_vld_q && (held_ext_q == evt_ext) && (held_code_q == ps2_key_data);
      if ((FILTER_REPEAT != 0) && evt_vld) begin
         if (evt_make) begin
            if (held_match) begin
               push = 1'b0;
            end else begin
               held_vld_d  = 1'b1;
               held_ext_d  = evt_ext;
               held_code_d = ps2_key_data;
            end
         end else if (held_match) begin
            held_vld_d = 1'b0;
         end
      end
   end

   // A pop frees the slot the same-cycle push needs, so full+pop still writes.
   always_comb begin
      pop        = event_ack && (count_q != '0);
      full       = (count_q == FULL_CNT);
      wr         = push && (!full || pop);
      ovf_set    = push && full && !pop;
      mem_d      = mem_q;
      if (wr) mem_d[wptr_q] = {evt_ext, evt_make, ps2_key_data};
      wptr_d     = wptr_q + AW'(wr);
      rptr_d     = rptr_q + AW'(pop);
      count_d    = count_q + (AW+1)'(wr) - (AW+1)'(pop);
      overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         held_vld_q  <= 1'b0;
         held_ext_q  <= 1'b0;
         held_code_q <= 8'h00;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         held_vld_q  <= held_vld_d;
         held_ext_q  <= held_ext_d;
         held_code_q <= held_code_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         mem_q       <= mem_d;
      end
   end

   assign head        = mem_q[rptr_q];
   assign event_ready = (count_q != '0);
   assign event_code  = event_ready ? head[7:0] : 8'h00;
   assign event_make  = event_ready ? head[8]   : 1'b0;
   assign event_ext   = event_ready ? head[9]   : 1'b0;
   assign count       = count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_keycode_queue.sv
// Directed bench: three configurations (default, no repeat filter, DEPTH=4) share one
// byte stream; expected events are queued at drive time and checked as they are popped.
module tb_ps2_keycode_queue;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [7:0] data = 8'h00;
   logic [2:0] ack = 3'b000;
   logic       clr = 1'b0;

   logic       r0, e0, m0, o0, r1, e1, m1, o1, r2, e2, m2, o2;
   logic [7:0] c0, c1, c2;
   logic [3:0] n0, n1;
   logic [2:0] n2;

   logic [2:0] rdy, ovf;
   logic [9:0] hd [3];
   logic [7:0] cnt [3];

   logic [9:0] q0 [$];
   logic [9:0] q1 [$];
   logic [9:0] q2 [$];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ps2_keycode_queue #(.DEPTH(8), .FILTER_REPEAT(1)) u0 (
      .clk(clk), .reset(reset), .ps2_key_en(en), .ps2_key_data(data),
      .event_ack(ack[0]), .ovf_clr(clr), .event_ready(r0), .event_code(c0),
      .event_ext(e0), .event_make(m0), .count(n0), .overflow(o0));

   ps2_keycode_queue #(.DEPTH(8), .FILTER_REPEAT(0)) u1 (
      .clk(clk), .reset(reset), .ps2_key_en(en), .ps2_key_data(data),
      .event_ack(ack[1]), .ovf_clr(clr), .event_ready(r1), .event_code(c1),
      .event_ext(e1), .event_make(m1), .count(n1), .overflow(o1));

   ps2_keycode_queue #(.DEPTH(4), .FILTER_REPEAT(1)) u2 (
      .clk(clk), .reset(reset), .ps2_key_en(en), .ps2_key_data(data),
      .event_ack(ack[2]), .ovf_clr(clr), .event_ready(r2), .event_code(c2),
      .event_ext(e2), .event_make(m2), .count(n2), .overflow(o2));

   assign rdy    = {r2, r1, r0};
   assign ovf    = {o2, o1, o0};
   assign hd[0]  = {e0, m0, c0};
   assign hd[1]  = {e1, m1, c1};
   assign hd[2]  = {e2, m2, c2};
   assign cnt[0] = {4'b0, n0};
   assign cnt[1] = {4'b0, n1};
   assign cnt[2] = {5'b0, n2};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int k, input logic ext, input logic mk, input logic [7:0] code);
      case (k)
         0:       q0.push_back({ext, mk, code});
         1:       q1.push_back({ext, mk, code});
         default: q2.push_back({ext, mk, code});
      endcase
   endtask

   task automatic pop_exp(input int k, output logic [9:0] e);
      case (k)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   function automatic int qsize(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      en   = 1'b1;
      data = b;
      tick();
      en   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en    = 1'b0;
      ack   = 3'b000;
      clr   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
   endtask

   // Pops every expected entry of instance k through the ack handshake, then checks empty.
   task automatic drain(input int k);
      logic [9:0] e;
      int n;
      n = qsize(k);
      for (int i = 0; i < n; i++) begin
         pop_exp(k, e);
         check($sformatf("head%0d_%0d", k, i), {5'b0, rdy[k], hd[k]}, {5'b0, 1'b1, e});
         ack[k] = 1'b1;
         tick();
         ack[k] = 1'b0;
      end
      check($sformatf("empty%0d", k), {7'b0, rdy[k], cnt[k]}, 16'h0000);
   endtask

   logic [7:0] b2b_byte [10] = '{8'h21, 8'h22, 8'hF0, 8'h21, 8'hE0, 8'h23, 8'hE0, 8'hF0, 8'h23, 8'h00};
   logic [9:0] b2b_evt  [10] = '{10'h121, 10'h122, 10'h000, 10'h021, 10'h000,
                                 10'h323, 10'h000, 10'h000, 10'h223, 10'h000};
   logic       b2b_has  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      do_reset();
      check("rst_ready", {15'b0, rdy[0]}, 16'h0000);
      check("rst_count", {8'b0, cnt[0]}, 16'h0000);
      check("rst_ovf",   {15'b0, ovf[0]}, 16'h0000);
      check("rst_head",  {6'b0, hd[0]}, 16'h0000);

      // make / break of an ordinary key
      send(8'h1C);
      push_exp(0, 1'b0, 1'b1, 8'h1C);
      check("latency_head", {5'b0, rdy[0], hd[0]}, {5'b0, 1'b1, 10'h11C});
      send(8'hF0);
      send(8'h1C);
      push_exp(0, 1'b0, 1'b0, 8'h1C);
      check("basic_count", {8'b0, cnt[0]}, 16'd2);
      drain(0);

      // extended make / break
      do_reset();
      send(8'hE0);
      check("no_prefix_entry", {15'b0, rdy[0]}, 16'h0000);
      send(8'h75);
      push_exp(0, 1'b1, 1'b1, 8'h75);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      push_exp(0, 1'b1, 1'b0, 8'h75);
      check("ext_count", {8'b0, cnt[0]}, 16'd2);
      drain(0);

      // repeat filter on (u0) vs off (u1)
      do_reset();
      send(8'h1C);
      push_exp(0, 1'b0, 1'b1, 8'h1C);
      push_exp(1, 1'b0, 1'b1, 8'h1C);
      send(8'h1C);
      push_exp(1, 1'b0, 1'b1, 8'h1C);
      send(8'h1C);
      push_exp(1, 1'b0, 1'b1, 8'h1C);
      send(8'hF0);
      send(8'h1C);
      push_exp(0, 1'b0, 1'b0, 8'h1C);
      push_exp(1, 1'b0, 1'b0, 8'h1C);
      send(8'h1C);
      push_exp(0, 1'b0, 1'b1, 8'h1C);
      push_exp(1, 1'b0, 1'b1, 8'h1C);
      check("filt_count",   {8'b0, cnt[0]}, 16'd3);
      check("nofilt_count", {8'b0, cnt[1]}, 16'd5);
      drain(0);
      drain(1);

      // DEPTH=4 overflow, full push+pop, clear priority
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(8'h15 + 8'(i));
         if (i < 4) push_exp(2, 1'b0, 1'b1, 8'h15 + 8'(i));
      end
      check("full_count", {8'b0, cnt[2]}, 16'd4);
      check("full_ovf",   {15'b0, ovf[2]}, 16'h0001);
      check("full_head",  {6'b0, hd[2]}, 16'h0115);
      ack[2] = 1'b1;
      send(8'h1A);
      ack[2] = 1'b0;
      begin
         logic [9:0] gone;
         pop_exp(2, gone);
      end
      push_exp(2, 1'b0, 1'b1, 8'h1A);
      check("pushpop_count", {8'b0, cnt[2]}, 16'd4);
      check("pushpop_ovf",   {15'b0, ovf[2]}, 16'h0001);
      check("pushpop_head",  {6'b0, hd[2]}, 16'h0116);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("ovf_clr", {15'b0, ovf[2]}, 16'h0000);
      clr = 1'b1;
      send(8'h1B);
      clr = 1'b0;
      check("ovf_set_wins", {15'b0, ovf[2]}, 16'h0001);
      check("ovf_set_count", {8'b0, cnt[2]}, 16'd4);
      drain(2);
      ack[2] = 1'b1;
      tick();
      ack[2] = 1'b0;
      check("ack_empty", {7'b0, rdy[2], cnt[2]}, 16'h0000);

      // discards and reset mid-prefix
      do_reset();
      send(8'hFA);
      send(8'hAA);
      send(8'hE0);
      check("discard_none", {15'b0, rdy[0]}, 16'h0000);
      do_reset();
      send(8'h1C);
      push_exp(0, 1'b0, 1'b1, 8'h1C);
      check("post_rst_count", {8'b0, cnt[0]}, 16'd1);
      drain(0);

      // back-to-back bytes with ack held every cycle
      do_reset();
      for (int i = 0; i < 13; i++) begin
         logic [9:0] e;
         ack[0] = 1'b1;
         if (i < 10) begin
            en   = 1'b1;
            data = b2b_byte[i];
            if (b2b_has[i]) push_exp(0, b2b_evt[i][9], b2b_evt[i][8], b2b_evt[i][7:0]);
         end else begin
            en = 1'b0;
         end
         tick();
         check($sformatf("b2b_rdy%0d", i), {15'b0, rdy[0]}, {15'b0, (q0.size() != 0)});
         if (q0.size() != 0) begin
            pop_exp(0, e);
            check($sformatf("b2b_head%0d", i), {6'b0, hd[0]}, {6'b0, e});
         end
         check($sformatf("b2b_cnt%0d", i), {15'b0, (cnt[0] <= 8'd1)}, 16'h0001);
      end
      en     = 1'b0;
      ack[0] = 1'b0;
      check("b2b_done", {7'b0, rdy[0], cnt[0]}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_keycode_queue.md
# ps2_keycode_queue

Parametrised successor to the single-event keycode recognizer. It parses the PS/2 set-2 byte stream from `PS2_Controller` into make/break/extended key events and buffers them in a DEPTH-entry FIFO with a valid/ack handshake. It optionally suppresses typematic auto-repeat and flags lost events. It sits between `PS2_Controller` and any consumer, such as a CPU port, a text-entry FSM or the hex-display demos.

## Interface
- `DEPTH`, default 8: number of FIFO entries; must be a power of two and at least 2.
- `FILTER_REPEAT`, default 1: when 1, a make event whose {ext, code} equals the currently held key is dropped.
- `clk` input, 1 bit: the single clock (CLOCK_50 domain).
- `reset` input, 1 bit: synchronous, active-high reset.
- `ps2_key_en` input, 1 bit: one-cycle strobe; `ps2_key_data` is valid in that cycle.
- `ps2_key_data` input, 8 bits: received byte.
- `event_ack` input, 1 bit: consumer pops the head entry.
- `ovf_clr` input, 1 bit: clears `overflow`.
- `event_ready` output, 1 bit: FIFO non-empty.
- `event_code` output, 8 bits: head scan code.
- `event_ext` output, 1 bit: head event was E0-prefixed.
- `event_make` output, 1 bit: head is a make event (1) or a break event (0).
- `count` output, $clog2(DEPTH)+1 bits: current number of entries.
- `overflow` output, 1 bit: sticky flag; an event was dropped because the FIFO was full.

## Operation
- The parser FSM has four states: IDLE, EXT, BRK, EXT_BRK. It advances only on cycles where `ps2_key_en`=1.
  - IDLE: byte E0 goes to EXT; F0 goes to BRK.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT.
  - BRK or EXT_BRK: byte E0 goes to EXT (resynchronise); F0 stays in the current state.
- Discard bytes: 00, AA, E1, EE, FA, FC, FD, FE, FF. Each is dropped and the FSM returns to IDLE.
  - Because E1 is dropped, the Pause key appears as ordinary 14/77 make and break events.
- Any other byte completes an event, and the FSM returns to IDLE.
  - code = byte.
  - ext = 1 if the state was EXT or EXT_BRK.
  - make = 1 if the state was IDLE or EXT.
- Repeat filter (`FILTER_REPEAT`=1):
  - Register `held` = {valid, ext, code}.
  - A make event equal to `held` while valid is dropped. A dropped repeat does not count as overflow.
  - Any other make event is pushed and loads `held`.
  - A break event matching `held` clears `held.valid`. A break of any other key leaves `held` unchanged.
  - All breaks are pushed.
  - With `FILTER_REPEAT`=0, every completed event is pushed.
- FIFO behaviour:
  - Push writes {ext, make, code} at the write pointer. Pop advances the read pointer when `event_ack` and `event_ready` are both 1. `event_ack` while empty is ignored.
  - Push while full without a same-cycle pop: the new event is dropped and `overflow` is set to 1.
  - Push and pop in the same cycle when full: both take effect, `count` is unchanged, no overflow.
  - Push and pop in the same cycle when count=1: the entry is replaced, `event_ready` stays 1.
  - Pointers wrap modulo DEPTH; `count` distinguishes full from empty.
- While empty, `event_code`, `event_ext` and `event_make` are forced to 0.
- `overflow`: a set from an overflow event takes priority over `ovf_clr` in the same cycle.
- Reset values: FSM IDLE, `held.valid`=0, pointers 0, `count`=0, `event_ready`=0, all event fields 0, `overflow`=0.
- Reset during a partial sequence (e.g. after E0 F0) discards the prefix. The next byte is parsed from IDLE.

## Timing
- Latency: the event-completing byte strobed in cycle n is visible at the head in cycle n+1 if the FIFO was empty. `event_ready` and `count` are registered and update at the edge ending cycle n.
- Pop: `event_ack` high in cycle n means the next entry (or empty) is shown in cycle n+1.
- Throughput: one byte per cycle is accepted, with no back-pressure on the PS/2 side.
- Outputs come from registers or from the FIFO head via the read pointer; there is no combinational path from `ps2_key_data` to any output.

## Test plan
- Reset, then the byte sequence 1C, F0, 1C → two entries: {code=1C, ext=0, make=1} then {code=1C, ext=0, make=0}; `count`=2.
- E0 75, E0 F0 75 → {75, ext=1, make=1} then {75, ext=1, make=0}; no stray entry for E0 or F0.
- `FILTER_REPEAT`=1 with bytes 1C, 1C, 1C, F0 1C, 1C → entries: make 1C, break 1C, make 1C (3 total). With `FILTER_REPEAT`=0 the same bytes give 5 entries.
- `DEPTH`=4 with 5 make events of distinct codes and no ack → `count`=4, `overflow`=1, and the head is the first code. Then ack in the same cycle as a 6th push → `count`=4, `overflow` still 1, and the FIFO order is preserved. Then `ovf_clr` → `overflow`=0.
- FA, AA, E0, then reset, then 1C → a single entry {1C, ext=0, make=1}: prefix discarded, no entries for FA or AA.
- Back-to-back strobes with acks in every cycle → each event is seen exactly once, in order; `count` never exceeds 1 and never underflows.
